// File: rtl/pb_pkg.sv
// Shared types and constants for the pushbutton debouncer.
package pb_pkg;

    // Debounce state of one button channel.
    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } pb_state_t;

    // Default settle time in clock cycles.
    localparam int unsigned PB_DEBOUNCE_DEFAULT = 250000;

    // Button levels are active-low.
    localparam logic PB_LEVEL_PRESSED  = 1'b0;
    localparam logic PB_LEVEL_RELEASED = 1'b1;

    // Clean level reported while sitting in a given state: the accepted
    // level only changes when a wait state completes, so the wait states
    // still report the level they are trying to leave.
    function automatic logic pb_clean_level(input pb_state_t state);
        logic level;
        level = PB_LEVEL_RELEASED;
        if (state == PRESSED || state == RELEASE_WAIT) begin
            level = PB_LEVEL_PRESSED;
        end
        return level;
    endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One pushbutton channel: two-flop synchroniser, settle counter, debounce
// FSM and registered clean level / press / release pulses.
module pb_debounce_chan
    import pb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic not_reset,
    input  logic not_raw,
    output logic not_clean,
    output logic press_pulse,
    output logic release_pulse
);

    // Counter only ever needs to reach DEBOUNCE_CYCLES-1.
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    pb_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             press_q;
    logic             release_q;

    // Incremented count; only used while a wait is still short of its target,
    // so it can never wrap.
    assign cnt_d = cnt_q + CNT_W'(1);

    // Two-flop synchroniser, both stages resting at the released level.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            sync1_q <= PB_LEVEL_RELEASED;
            sync2_q <= PB_LEVEL_RELEASED;
        end else begin
            // NOTE: non-blocking so sync2_q takes last cycle's sync1_q; a
            // blocking assignment would collapse the two stages into one.
            sync1_q <= not_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce FSM with settle counter and registered clean level and pulses.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            clean_q   <= PB_LEVEL_RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            // Pulses default low so each lasts exactly one cycle.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                RELEASED: begin
                    if (sync2_q == PB_LEVEL_PRESSED) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (sync2_q == PB_LEVEL_RELEASED) begin
                        // Bounce (including one on the final cycle): abandon.
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        clean_q <= pb_clean_level(PRESSED);
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                PRESSED: begin
                    if (sync2_q == PB_LEVEL_RELEASED) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_q == PB_LEVEL_PRESSED) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= RELEASED;
                        cnt_q     <= '0;
                        clean_q   <= pb_clean_level(RELEASED);
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= RELEASED;
                    cnt_q   <= '0;
                    clean_q <= PB_LEVEL_RELEASED;
                end
            endcase
        end
    end

    assign not_clean     = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/pb_debounce.sv
// Input conditioner for the two active-low board pushbuttons. Each button
// is synchronised and debounced independently; the clean levels feed the
// result selector, the pulses serve any later sequential consumer.
module pb_debounce
    import pb_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PB_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic not_reset,
    input  logic not_LEFT_raw,
    input  logic not_RIGHT_raw,
    output logic not_LEFT_clean,
    output logic not_RIGHT_clean,
    output logic left_press_pulse,
    output logic right_press_pulse,
    output logic left_release_pulse,
    output logic right_release_pulse
);

    // Left button channel.
    pb_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_left (
        .clk           (clk),
        .not_reset     (not_reset),
        .not_raw       (not_LEFT_raw),
        .not_clean     (not_LEFT_clean),
        .press_pulse   (left_press_pulse),
        .release_pulse (left_release_pulse)
    );

    // Right button channel; no interaction with the left one.
    pb_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_right (
        .clk           (clk),
        .not_reset     (not_reset),
        .not_raw       (not_RIGHT_raw),
        .not_clean     (not_RIGHT_clean),
        .press_pulse   (right_press_pulse),
        .release_pulse (right_release_pulse)
    );

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce with DEBOUNCE_CYCLES = 4. The stimulus
// process runs a run-length reference model and queues the expected pulse
// events; a monitor pops them each cycle and compares pulses and levels.
module tb_pb_debounce;

    localparam int N = 4;

    typedef struct {
        int edge_no;
        int ch;       // 0 = left, 1 = right
        bit press;
    } ev_t;

    logic clk       = 1'b0;
    logic not_reset = 1'b0;
    logic l_raw     = 1'b0;
    logic r_raw     = 1'b0;
    logic l_clean, r_clean;
    logic l_press, r_press, l_release, r_release;

    pb_debounce #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk                 (clk),
        .not_reset           (not_reset),
        .not_LEFT_raw        (l_raw),
        .not_RIGHT_raw       (r_raw),
        .not_LEFT_clean      (l_clean),
        .not_RIGHT_clean     (r_clean),
        .left_press_pulse    (l_press),
        .right_press_pulse   (r_press),
        .left_release_pulse  (l_release),
        .right_release_pulse (r_release)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int compared   = 0;
    int mismatched = 0;

    ev_t      exp_q[$];
    bit [1:0] m_clean = 2'b11;   // model's accepted level per channel
    int       m_run[2];          // consecutive samples differing from it
    bit [1:0] mon_clean = 2'b11; // level the monitor expects on the outputs
    logic [3:0] exp_p;
    ev_t      ev;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_cnt, act, exp);
        end
    endtask

    // Reference model: a new level is accepted once N+1 consecutive samples
    // differ from the accepted level; the output moves two edges after the
    // last of those samples (synchroniser delay).
    task automatic model_sample(input int c, input bit v, input int s);
        if (v != m_clean[c]) begin
            m_run[c]++;
            if (m_run[c] == N + 1) begin
                m_clean[c] = v;
                m_run[c]   = 0;
                exp_q.push_back('{edge_no: s + 2, ch: c, press: (v == 1'b0)});
            end
        end else begin
            m_run[c] = 0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge; they are sampled at the
    // next rising edge.
    task automatic step(input bit l, input bit r, input bit rst_n_v);
        @(negedge clk);
        if (!rst_n_v) begin
            // Reset wipes anything not yet presented.
            while (exp_q.size() > 0 && exp_q[$].edge_no > edge_cnt) void'(exp_q.pop_back());
            m_clean  = 2'b11;
            m_run[0] = 0;
            m_run[1] = 0;
        end
        not_reset = rst_n_v;
        l_raw     = l;
        r_raw     = r;
        if (rst_n_v) begin
            model_sample(0, l, edge_cnt + 1);
            model_sample(1, r, edge_cnt + 1);
        end
    endtask

    // Monitor: 1 time unit after each rising edge compare pulses and levels.
    always @(posedge clk) begin
        #1;
        if (!not_reset) begin
            check("reset_clean", int'({l_clean, r_clean}), 3);
            check("reset_pulses", int'({l_press, l_release, r_press, r_release}), 0);
            mon_clean = 2'b11;
        end else begin
            exp_p = 4'b0000;
            while (exp_q.size() > 0 && exp_q[0].edge_no <= edge_cnt) begin
                ev = exp_q.pop_front();
                if (ev.edge_no < edge_cnt) begin
                    check("late_event", ev.edge_no, edge_cnt);
                end else begin
                    exp_p[(ev.ch == 0 ? 2 : 0) + (ev.press ? 1 : 0)] = 1'b1;
                    mon_clean[ev.ch] = !ev.press;
                end
            end
            check("pulses", int'({l_press, l_release, r_press, r_release}), int'(exp_p));
            check("clean", int'({l_clean, r_clean}), int'({mon_clean[0], mon_clean[1]}));
        end
    end

    bit lv, rv;
    int lrem, rrem;

    initial begin
        m_run[0] = 0;
        m_run[1] = 0;
        // Reset held with both buttons pressed.
        repeat (5) step(0, 0, 0);
        // Clean left press, then release.
        repeat (10) step(0, 1, 1);
        repeat (10) step(1, 1, 1);
        // Bounce: low 3, high 2, then low held.
        repeat (3) step(0, 1, 1);
        repeat (2) step(1, 1, 1);
        repeat (10) step(0, 1, 1);
        // Release with bounce: 1,0,1,1,1...
        step(1, 1, 1);
        step(0, 1, 1);
        repeat (10) step(1, 1, 1);
        // Reversal on the last counting cycle: exactly N low samples.
        repeat (N) step(0, 1, 1);
        repeat (6) step(1, 1, 1);
        // Simultaneous presses and releases.
        repeat (10) step(0, 0, 1);
        repeat (10) step(1, 1, 1);
        // Reset mid-wait (cnt = 2), then a fresh full settle.
        repeat (5) step(0, 0, 1);
        repeat (3) step(0, 0, 0);
        repeat (10) step(0, 0, 1);
        repeat (10) step(1, 1, 1);
        // Randomised runs mixing bounces, boundary-length runs and resets.
        lv   = 1'b1;
        rv   = 1'b1;
        lrem = 0;
        rrem = 0;
        for (int i = 0; i < 3000; i++) begin
            if (lrem == 0) begin
                lv   = ~lv;
                lrem = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, N + 1))
                                                   : int'($urandom_range(N + 1, 3 * N));
            end
            if (rrem == 0) begin
                rv   = ~rv;
                rrem = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, N + 1))
                                                   : int'($urandom_range(N + 1, 3 * N));
            end
            lrem--;
            rrem--;
            if ($urandom_range(0, 199) == 0) begin
                repeat ($urandom_range(1, 3)) step(lv, rv, 0);
            end else begin
                step(lv, rv, 1);
            end
        end
        repeat (12) step(1, 1, 1);
        @(negedge clk);
        check("drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
